// File: rtl/mux_n_sel_reg.sv
// mux_n_sel_reg: registered N-way selector with valid/ready handshakes; optional round-robin via MUX_N_SEL_REG_RR_EN
module mux_n_sel_reg #(
   parameter int WIDTH = 16,
   parameter int N     = 8,
   parameter int SELW  = $clog2(N)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   input  logic [SELW-1:0]    sel,
   input  logic               mode,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [SELW-1:0]    out_chan
);
   logic            can_load;
   logic            found;
   logic            acc;
   logic [SELW-1:0] ch;
   logic [WIDTH-1:0] d;

   assign can_load = !out_valid || out_ready;

`ifdef MUX_N_SEL_REG_RR_EN
   logic [SELW-1:0] rr_ptr;
   logic [SELW-1:0] rr_ch;
   logic [SELW-1:0] idx;
   logic            rr_found;

   // scan from rr_ptr upward with wrap; the lowest offset with a valid input wins
   always_comb begin
      rr_ch = '0;
      rr_found = 1'b0;
      idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = SELW'((int'(rr_ptr) + k) % N);
         if (in_valid[idx]) begin
            rr_ch = idx;
            rr_found = 1'b1;
         end
      end
   end

   assign ch    = mode ? rr_ch : sel;
   assign found = mode ? rr_found : 1'b1;

   // advance the pointer past the channel just accepted, only in round-robin mode
   always_ff @(posedge clk or posedge reset)
      if (reset) rr_ptr <= '0;
      else if (acc && mode) rr_ptr <= (ch == SELW'(N - 1)) ? '0 : ch + 1'b1;
`else
   logic unused_mode;
   assign unused_mode = mode;
   assign ch    = sel;
   assign found = 1'b1;
`endif

   // one-hot ready for the chosen channel; a select beyond N-1 matches nothing
   always_comb begin
      in_ready = '0;
      for (int i = 0; i < N; i++) in_ready[i] = !reset && can_load && found && (ch == SELW'(i));
   end

   assign acc = |(in_ready & in_valid);

   // pick the data word of the ready channel
   always_comb begin
      d = '0;
      for (int i = 0; i < N; i++) if (in_ready[i]) d = in_data[i*WIDTH +: WIDTH];
   end

   // single-entry output register: load on accept, clear valid on drain, hold otherwise
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         out_data  <= '0;
         out_chan  <= '0;
         out_valid <= 1'b0;
      end else if (acc) begin
         out_data  <= d;
         out_chan  <= ch;
         out_valid <= 1'b1;
      end else if (out_ready) out_valid <= 1'b0;
endmodule

// File: tb/tb_mux_n_sel_reg.sv
// tb_mux_n_sel_reg: directed self-checking bench for mux_n_sel_reg (N=8 and N=6 instances)
module tb_mux_n_sel_reg;
   logic          clk = 1'b0;
   logic          reset;
   logic [127:0]  in_data;
   logic [7:0]    in_valid;
   logic [7:0]    in_ready;
   logic [2:0]    sel;
   logic          mode;
   logic [15:0]   out_data;
   logic          out_valid;
   logic          out_ready;
   logic [2:0]    out_chan;

   logic [95:0]   in_data6;
   logic [5:0]    in_valid6;
   logic [5:0]    in_ready6;
   logic [2:0]    sel6;
   logic          mode6;
   logic [15:0]   out_data6;
   logic          out_valid6;
   logic          out_ready6;
   logic [2:0]    out_chan6;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mux_n_sel_reg #(.WIDTH(16), .N(8)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .sel(sel), .mode(mode), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_chan(out_chan)
   );

   mux_n_sel_reg #(.WIDTH(16), .N(6)) dut6 (
      .clk(clk), .reset(reset), .in_data(in_data6), .in_valid(in_valid6), .in_ready(in_ready6),
      .sel(sel6), .mode(mode6), .out_data(out_data6), .out_valid(out_valid6), .out_ready(out_ready6),
      .out_chan(out_chan6)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   initial begin
      reset = 1'b1;
      in_data = '0;
      in_data[5*16 +: 16] = 16'hBEEF;
      in_valid = 8'h20;
      sel = 3'd5;
      mode = 1'b0;
      out_ready = 1'b1;
      in_data6 = '0;
      in_valid6 = 6'h3F;
      sel6 = 3'd7;
      mode6 = 1'b0;
      out_ready6 = 1'b1;
      repeat (3) tick;
      #1;
      check("rst_valid", out_valid, 0);
      check("rst_ready", in_ready, 0);
      check("rst_data", out_data, 0);
      check("rst_chan", out_chan, 0);
      reset = 1'b0;
      #1;
      check("fix_ready", in_ready, 8'h20);
      check("oor_ready", in_ready6, 0);
      tick;
      check("fix_data", out_data, 16'hBEEF);
      check("fix_chan", out_chan, 5);
      check("fix_valid", out_valid, 1);
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         in_data[5*16 +: 16] = 16'h1000 + 16'(k);
         #1;
         check("bp_ready", in_ready, 0);
         tick;
         check("bp_data", out_data, 16'hBEEF);
         check("bp_valid", out_valid, 1);
      end
      check("oor_valid", out_valid6, 0);
      in_data[5*16 +: 16] = 16'hCAFE;
      out_ready = 1'b1;
      #1;
      check("bp_release_ready", in_ready, 8'h20);
      tick;
      check("bp_swap_data", out_data, 16'hCAFE);
      check("bp_swap_valid", out_valid, 1);
      in_valid = 8'h00;
      tick;
      check("drain_valid", out_valid, 0);
      check("drain_data", out_data, 16'hCAFE);
      check("drain_chan", out_chan, 5);
      sel = 3'd3;
      #1;
      check("fix_ready_novalid", in_ready, 8'h08);
      sel = 3'd2;
      in_valid = 8'h04;
      in_data[2*16 +: 16] = 16'h1234;
      tick;
      check("sel2_data", out_data, 16'h1234);
      check("sel2_chan", out_chan, 2);
      in_valid = 8'h00;
      sel6 = 3'd5;
      in_data6[5*16 +: 16] = 16'h5A5A;
      #1;
      check("n6_ready", in_ready6, 6'h20);
      tick;
      check("n6_chan", out_chan6, 5);
      check("n6_data", out_data6, 16'h5A5A);
      in_valid6 = 6'h00;
`ifdef MUX_N_SEL_REG_RR_EN
      tick;
      mode = 1'b1;
      in_valid = 8'hFF;
      for (int k = 0; k < 10; k++) begin
         tick;
         check("rr_fair_chan", out_chan, k % 8);
      end
      in_valid = 8'h01;
      tick;
      check("rr_set_chan", out_chan, 0);
      in_valid = 8'h81;
      tick;
      check("rr_wrap_a", out_chan, 7);
      tick;
      check("rr_wrap_b", out_chan, 0);
      tick;
      check("rr_wrap_c", out_chan, 7);
      mode = 1'b0;
      in_valid = 8'h00;
`endif
      sel = 3'd5;
      in_valid = 8'h20;
      in_data[5*16 +: 16] = 16'hBEEF;
      tick;
      check("pre_rst_valid", out_valid, 1);
      out_ready = 1'b0;
      #1;
      reset = 1'b1;
      #1;
      check("arst_valid", out_valid, 0);
      check("arst_data", out_data, 0);
      check("arst_chan", out_chan, 0);
      check("arst_ready", in_ready, 0);
      reset = 1'b0;
      out_ready = 1'b1;
      #1;
      check("post_rst_ready", in_ready, 8'h20);
      tick;
      check("post_rst_valid", out_valid, 1);
      check("post_rst_data", out_data, 16'hBEEF);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
